// File: rtl/mips_pkg.sv
// Shared MIPS EX-stage definitions: HI/LO unit opcodes and FSM state encodings.
package mips_pkg;

   localparam logic [2:0] MD_OP_MULT  = 3'd0;
   localparam logic [2:0] MD_OP_MULTU = 3'd1;
   localparam logic [2:0] MD_OP_DIV   = 3'd2;
   localparam logic [2:0] MD_OP_DIVU  = 3'd3;
   localparam logic [2:0] MD_OP_MTHI  = 3'd4;
   localparam logic [2:0] MD_OP_MTLO  = 3'd5;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_FIX  = 2'd2
   } md_state_e;

endpackage

// File: rtl/md_datapath.sv
// Shared 2*WIDTH accumulator/remainder shift register for radix-2 multiply
// (shift-add) and restoring divide (shift-subtract), one step per cycle.
module md_datapath #(
   parameter int unsigned WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_i,
   input  logic               step_i,
   input  logic               is_div_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic [2*WIDTH-1:0] acc_o
);

   localparam int unsigned DW = 2 * WIDTH;

   logic [DW-1:0]    acc_q, acc_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [WIDTH:0]   sum;
   logic [WIDTH+1:0] diff;

   // Low half starts as multiplier/dividend; opnd holds multiplicand/divisor.
   always_comb begin
      sum    = {1'b0, acc_q[DW-1:WIDTH]} + {1'b0, opnd_q};
      diff   = {1'b0, acc_q[DW-1:WIDTH-1]} - {2'b00, opnd_q};
      acc_d  = acc_q;
      opnd_d = opnd_q;
      if (load_i) begin
         acc_d  = {{WIDTH{1'b0}}, a_i};
         opnd_d = b_i;
      end else if (step_i) begin
         if (is_div_i) begin
            acc_d = diff[WIDTH+1] ? {acc_q[DW-2:0], 1'b0}
                                  : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
         end else begin
            acc_d = acc_q[0] ? {sum, acc_q[WIDTH-1:1]}
                             : {1'b0, acc_q[DW-1:1]};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q  <= '0;
         opnd_q <= '0;
      end else begin
         acc_q  <= acc_d;
         opnd_q <= opnd_d;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: FSM, iteration counter, sign fix-up and
// HI/LO registers around md_datapath; drives the pipeline stall request.
module mult_div_unit
   import mips_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned ITERS = 32
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Start,
   input  logic [2:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             HiLoRd,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo,
   output logic             Busy,
   output logic             Done,
   output logic             Stall
);

   localparam int unsigned CNT_W = $clog2(ITERS);
   localparam int unsigned DW    = 2 * WIDTH;

   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, a_q, a_d;
   logic             busy_q, busy_d, done_q, done_d;
   logic             div_q, div_d, neg_q, neg_d, neg_rem_q, neg_rem_d, dbz_q, dbz_d;

   logic             is_signed, is_div, a_neg, b_neg, dp_load, dp_step;
   logic [WIDTH-1:0] a_mag, b_mag, quot, rem;
   logic [DW-1:0]    acc;

   // Operand magnitudes and signs for the op being presented.
   always_comb begin
      is_signed = (Op == MD_OP_MULT) || (Op == MD_OP_DIV);
      is_div    = (Op == MD_OP_DIV)  || (Op == MD_OP_DIVU);
      a_neg     = is_signed & A[WIDTH-1];
      b_neg     = is_signed & B[WIDTH-1];
      a_mag     = a_neg ? -A : A;
      b_mag     = b_neg ? -B : B;
   end

   md_datapath #(.WIDTH(WIDTH)) u_dp (
      .clk      (Clk),
      .rst_n    (Rst),
      .load_i   (dp_load),
      .step_i   (dp_step),
      .is_div_i (div_q),
      .a_i      (a_mag),
      .b_i      (b_mag),
      .acc_o    (acc)
   );

   assign quot = acc[WIDTH-1:0];
   assign rem  = acc[DW-1:WIDTH];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      a_d       = a_q;
      done_d    = 1'b0;
      div_d     = div_q;
      neg_d     = neg_q;
      neg_rem_d = neg_rem_q;
      dbz_d     = dbz_q;
      dp_load   = 1'b0;
      dp_step   = 1'b0;
      case (state_q)
         MD_IDLE: begin
            if (Start) begin
               case (Op)
                  MD_OP_MULT, MD_OP_MULTU, MD_OP_DIV, MD_OP_DIVU: begin
                     dp_load   = 1'b1;
                     state_d   = MD_CALC;
                     cnt_d     = '0;
                     div_d     = is_div;
                     neg_d     = a_neg ^ b_neg;
                     neg_rem_d = a_neg;
                     dbz_d     = is_div && (B == '0);
                     a_d       = A;
                  end
                  MD_OP_MTHI: hi_d = A;
                  MD_OP_MTLO: lo_d = A;
                  default: ;
               endcase
            end
         end
         MD_CALC: begin
            dp_step = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(ITERS - 1)) state_d = MD_FIX;
         end
         MD_FIX: begin
            state_d = MD_IDLE;
            done_d  = 1'b1;
            if (dbz_q) begin
               hi_d = a_q;
               lo_d = '1;
            end else if (div_q) begin
               lo_d = neg_q     ? -quot : quot;
               hi_d = neg_rem_q ? -rem  : rem;
            end else begin
               {hi_d, lo_d} = neg_q ? -acc : acc;
            end
         end
         default: state_d = MD_IDLE;
      endcase
      busy_d = (state_d != MD_IDLE);
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q   <= MD_IDLE;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         a_q       <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         div_q     <= 1'b0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         dbz_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         a_q       <= a_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         div_q     <= div_d;
         neg_q     <= neg_d;
         neg_rem_q <= neg_rem_d;
         dbz_q     <= dbz_d;
      end
   end

   assign Hi    = hi_q;
   assign Lo    = lo_q;
   assign Busy  = busy_q;
   assign Done  = done_q;
   assign Stall = busy_q & (Start | HiLoRd);

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit against an arithmetic HI/LO reference.
module tb_mult_div_unit;
   import mips_pkg::*;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        Start;
   logic [2:0]  Op;
   logic [31:0] A, B;
   logic        HiLoRd;
   logic [31:0] Hi, Lo;
   logic        Busy, Done, Stall;

   int n_chk = 0;
   int n_err = 0;
   logic [31:0] hi_m = 32'h0;
   logic [31:0] lo_m = 32'h0;

   mult_div_unit #(.WIDTH(32), .ITERS(32)) dut (
      .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B), .HiLoRd(HiLoRd),
      .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done), .Stall(Stall)
   );

   always #5 Clk = ~Clk;

   // MIPS HI/LO semantics with plain 64-bit arithmetic.
   function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] h, output logic [31:0] l);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      h = 32'h0;
      l = 32'h0;
      case (op)
         MD_OP_MULT: begin p = sa * sb; {h, l} = p; end
         MD_OP_MULTU: begin p = {32'h0, a} * {32'h0, b}; {h, l} = p; end
         MD_OP_DIV, MD_OP_DIVU: begin
            if (b == 32'h0) begin
               h = a;
               l = 32'hFFFF_FFFF;
            end else begin
               if (op == MD_OP_DIVU) begin
                  sa = longint'({32'h0, a});
                  sb = longint'({32'h0, b});
               end
               q = sa / sb;
               r = sa % sb;
               l = q[31:0];
               h = r[31:0];
            end
         end
         default: ;
      endcase
   endfunction

   // Issue one MULT/DIV op now; optionally poke HiLoRd/Start from the 5th busy cycle.
   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit poke);
      logic [31:0] eh, el;
      int edges;
      model(op, a, b, eh, el);
      Start = 1'b1; Op = op; A = a; B = b; HiLoRd = 1'b0;
      @(posedge Clk); #1;
      n_chk++;
      if (Busy !== 1'b1 || Done !== 1'b0) begin
         n_err++;
         $display("FAIL accept op=%0d: busy=%b done=%b, required busy=1 done=0", op, Busy, Done);
      end
      n_chk++;
      if (Stall !== 1'b1) begin
         n_err++;
         $display("FAIL stall_on_start: stall=%b required 1", Stall);
      end
      Start = 1'b0;
      edges = 0;
      while (Done !== 1'b1 && edges < 40) begin
         if (poke && edges >= 4) begin
            HiLoRd = 1'b1; Start = 1'b1; Op = MD_OP_MTHI; A = 32'hDEAD_BEEF;
         end
         #1;
         n_chk++;
         if (Busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_hold edge=%0d: busy=%b required 1", edges, Busy);
         end
         n_chk++;
         if (Stall !== (poke && edges >= 4)) begin
            n_err++;
            $display("FAIL stall edge=%0d: stall=%b required %b", edges, Stall, poke && edges >= 4);
         end
         n_chk++;
         if (Hi !== hi_m || Lo !== lo_m) begin
            n_err++;
            $display("FAIL hilo_hold edge=%0d: hi=%h lo=%h required hi=%h lo=%h",
                     edges, Hi, Lo, hi_m, lo_m);
         end
         @(posedge Clk); #1;
         edges++;
      end
      if (poke) begin
         n_chk++;
         if (Stall !== 1'b0) begin
            n_err++;
            $display("FAIL stall_done: stall=%b required 0", Stall);
         end
      end
      Start = 1'b0; HiLoRd = 1'b0;
      n_chk++;
      if (Done !== 1'b1 || edges != 33) begin
         n_err++;
         $display("FAIL latency op=%0d: done=%b after %0d edges, required done=1 after 33", op, Done, edges);
      end
      n_chk++;
      if (Busy !== 1'b0) begin
         n_err++;
         $display("FAIL busy_done: busy=%b required 0", Busy);
      end
      n_chk++;
      if (Hi !== eh || Lo !== el) begin
         n_err++;
         $display("FAIL result op=%0d a=%h b=%h: hi=%h lo=%h required hi=%h lo=%h",
                  op, a, b, Hi, Lo, eh, el);
      end
      hi_m = eh;
      lo_m = el;
   endtask

   task automatic test_reset();
      Rst = 1'b0; Start = 1'b1; Op = MD_OP_MULT; A = 32'h5; B = 32'h7; HiLoRd = 1'b1;
      repeat (3) @(posedge Clk);
      #1;
      n_chk++;
      if (Hi !== 32'h0 || Lo !== 32'h0 || Busy !== 1'b0 || Done !== 1'b0 || Stall !== 1'b0) begin
         n_err++;
         $display("FAIL reset: hi=%h lo=%h busy=%b done=%b stall=%b required all 0",
                  Hi, Lo, Busy, Done, Stall);
      end
      Start = 1'b0; HiLoRd = 1'b0;
      @(negedge Clk);
      Rst = 1'b1;
      hi_m = 32'h0; lo_m = 32'h0;
   endtask

   task automatic test_directed();
      do_op(MD_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      n_chk++;
      if (Hi !== 32'hFFFF_FFFE || Lo !== 32'h0000_0001) begin
         n_err++;
         $display("FAIL multu_max: hi=%h lo=%h required fffffffe 00000001", Hi, Lo);
      end
      do_op(MD_OP_MULT, -32'sd7, 32'd3, 1'b0);
      n_chk++;
      if (Hi !== 32'hFFFF_FFFF || Lo !== 32'hFFFF_FFEB) begin
         n_err++;
         $display("FAIL mult_neg: hi=%h lo=%h required ffffffff ffffffeb", Hi, Lo);
      end
      do_op(MD_OP_DIV, -32'sd7, 32'd2, 1'b0);
      n_chk++;
      if (Hi !== 32'hFFFF_FFFF || Lo !== 32'hFFFF_FFFD) begin
         n_err++;
         $display("FAIL div_neg: hi=%h lo=%h required ffffffff fffffffd", Hi, Lo);
      end
      do_op(MD_OP_DIVU, 32'd100, 32'd0, 1'b0);
      n_chk++;
      if (Hi !== 32'd100 || Lo !== 32'hFFFF_FFFF) begin
         n_err++;
         $display("FAIL div_zero: hi=%h lo=%h required 00000064 ffffffff", Hi, Lo);
      end
      do_op(MD_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      n_chk++;
      if (Hi !== 32'h0 || Lo !== 32'h8000_0000) begin
         n_err++;
         $display("FAIL div_ovf: hi=%h lo=%h required 00000000 80000000", Hi, Lo);
      end
      do_op(MD_OP_DIV, -32'sd9, 32'd0, 1'b0);
   endtask

   task automatic test_stall();
      do_op(MD_OP_MULT, 32'd1234, -32'sd5, 1'b1);
      do_op(MD_OP_DIVU, 32'hFFFF_FFF0, 32'd7, 1'b1);
   endtask

   task automatic test_mthi_mtlo();
      @(negedge Clk);
      Start = 1'b1; Op = MD_OP_MTHI; A = 32'h1234;
      @(posedge Clk); #1;
      n_chk++;
      if (Hi !== 32'h1234 || Busy !== 1'b0 || Done !== 1'b0) begin
         n_err++;
         $display("FAIL mthi: hi=%h busy=%b done=%b required 00001234 0 0", Hi, Busy, Done);
      end
      Op = MD_OP_MTLO; A = 32'h5678;
      @(posedge Clk); #1;
      n_chk++;
      if (Hi !== 32'h1234 || Lo !== 32'h5678 || Busy !== 1'b0) begin
         n_err++;
         $display("FAIL mtlo: hi=%h lo=%h busy=%b required 00001234 00005678 0", Hi, Lo, Busy);
      end
      Op = 3'd6; A = 32'hAAAA_5555;
      @(posedge Clk); #1;
      Op = 3'd7;
      @(posedge Clk); #1;
      n_chk++;
      if (Hi !== 32'h1234 || Lo !== 32'h5678 || Busy !== 1'b0 || Done !== 1'b0) begin
         n_err++;
         $display("FAIL nop: hi=%h lo=%h busy=%b done=%b required 00001234 00005678 0 0",
                  Hi, Lo, Busy, Done);
      end
      Start = 1'b0;
      hi_m = 32'h1234; lo_m = 32'h5678;
   endtask

   task automatic test_reset_abort();
      @(negedge Clk);
      Start = 1'b1; Op = MD_OP_DIVU; A = 32'd10; B = 32'd3;
      @(posedge Clk); #1;
      Start = 1'b0;
      repeat (11) @(posedge Clk);
      #2;
      Rst = 1'b0;
      #1;
      n_chk++;
      if (Hi !== 32'h0 || Lo !== 32'h0 || Busy !== 1'b0 || Done !== 1'b0) begin
         n_err++;
         $display("FAIL abort: hi=%h lo=%h busy=%b done=%b required 0 0 0 0", Hi, Lo, Busy, Done);
      end
      @(negedge Clk);
      Rst = 1'b1;
      repeat (30) @(posedge Clk);
      #1;
      n_chk++;
      if (Hi !== 32'h0 || Lo !== 32'h0 || Busy !== 1'b0 || Done !== 1'b0) begin
         n_err++;
         $display("FAIL abort_residue: hi=%h lo=%h busy=%b done=%b required 0 0 0 0",
                  Hi, Lo, Busy, Done);
      end
      hi_m = 32'h0; lo_m = 32'h0;
      do_op(MD_OP_MULTU, 32'd6, 32'd7, 1'b0);
      n_chk++;
      if (Lo !== 32'd42 || Hi !== 32'h0) begin
         n_err++;
         $display("FAIL post_abort: hi=%h lo=%h required 0 42", Hi, Lo);
      end
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   task automatic test_back_to_back();
      for (int i = 0; i < 40; i++) begin
         do_op(3'($urandom_range(0, 3)), pick(), pick(), ($urandom_range(0, 3) == 0));
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_stall();
      test_mthi_mtlo();
      test_reset_abort();
      test_back_to_back();
      @(posedge Clk); #1;
      n_chk++;
      if (Done !== 1'b0 || Busy !== 1'b0) begin
         n_err++;
         $display("FAIL done_pulse: done=%b busy=%b required 0 0", Done, Busy);
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
